// File: rtl/asic_rstseq.sv
// Reset sequencer: synchronizes release of the chip reset, then releases N
// domain resets one after another, GAP clock cycles apart.
module asic_rstseq #(
    parameter int N        = 4,
    parameter int SYNCPIPE = 2,
    parameter int GAP      = 8,
    parameter     PROP     = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         swreset,
    output logic [N-1:0] nrst_out,
    output logic         ready
);

    localparam int GW = $clog2(GAP + 1);
    localparam int IW = $clog2(N + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [N-1:0]  FIRST_BIT = N'(1);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_SYNC = 3'd1,
        ST_HOLD = 3'd2,
        ST_SEQ  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // PROP is a pass-through tag with no effect on the logic.
    if (PROP == "") begin : g_prop_empty
    end

    logic [SYNCPIPE-1:0] sync_r;
    logic                synced_s;
    state_t              state_r, state_next_s;
    logic [GW-1:0]       gap_r, gap_next_s;
    logic [IW-1:0]       idx_r, idx_next_s;
    logic [N-1:0]        nrst_r, nrst_next_s, nrst_shift_s;
    logic                ready_r, ready_next_s;

    assign synced_s = sync_r[SYNCPIPE-1];

    // Release synchronizer: ones shift in once nreset is deasserted.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNCPIPE-2:0], 1'b1};
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_next_s = state_r;
        gap_next_s   = gap_r;
        idx_next_s   = idx_r;
        nrst_next_s  = nrst_r;
        ready_next_s = ready_r;
        nrst_shift_s = nrst_r << 1;
        nrst_shift_s[0] = 1'b1;

        case (state_r)
            ST_RST, ST_SYNC, ST_HOLD: begin
                if (swreset) begin
                    nrst_next_s  = '0;
                    ready_next_s = 1'b0;
                    gap_next_s   = '0;
                    idx_next_s   = '0;
                    state_next_s = synced_s ? ST_HOLD : ST_SYNC;
                end else if (synced_s) begin
                    // Entry into sequencing releases bit 0 on this same edge.
                    nrst_next_s = FIRST_BIT;
                    gap_next_s  = '0;
                    idx_next_s  = IW'(1);
                    if (N == 1) begin
                        state_next_s = ST_DONE;
                        ready_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_SEQ;
                        ready_next_s = 1'b0;
                    end
                end else begin
                    state_next_s = ST_SYNC;
                end
            end
            ST_SEQ: begin
                if (swreset) begin
                    nrst_next_s  = '0;
                    ready_next_s = 1'b0;
                    gap_next_s   = '0;
                    idx_next_s   = '0;
                    state_next_s = ST_HOLD;
                end else if (gap_r == GAP_LAST) begin
                    gap_next_s  = '0;
                    nrst_next_s = nrst_shift_s;
                    idx_next_s  = idx_r + IW'(1);
                    if (idx_r == IDX_LAST) begin
                        state_next_s = ST_DONE;
                        ready_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_SEQ;
                    end
                end else begin
                    gap_next_s = gap_r + GW'(1);
                end
            end
            ST_DONE: begin
                if (swreset) begin
                    nrst_next_s  = '0;
                    ready_next_s = 1'b0;
                    gap_next_s   = '0;
                    idx_next_s   = '0;
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                nrst_next_s  = '0;
                ready_next_s = 1'b0;
                gap_next_s   = '0;
                idx_next_s   = '0;
                state_next_s = ST_SYNC;
            end
        endcase
    end

    // State, counters and registered outputs; nreset clears everything at once.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= ST_RST;
            gap_r   <= '0;
            idx_r   <= '0;
            nrst_r  <= '0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            gap_r   <= gap_next_s;
            idx_r   <= idx_next_s;
            nrst_r  <= nrst_next_s;
            ready_r <= ready_next_s;
        end
    end

    assign nrst_out = nrst_r;
    assign ready    = ready_r;

endmodule
